// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   CPU-side initiator for coprocessor1. Holds the FP register file, accepts
//   decoded COP1 ops (fd <= fs OP ft) over a valid/ready handshake, snapshots
//   the operands onto the coprocessor inputs, waits RESULT_LAT cycles and
//   writes floatRes back to fd. Also services mtc1 writes and mfc1 reads.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   issue_valid/ready   op handshake (ready only in IDLE)
//   issue_op/fs/ft/fd   op code and register addresses
//   mtc1_en/addr/data   integer-core write into the FP file (any state)
//   mfc1_addr/data      combinational read of stored FP state
//   cp_data1/2, cp_op   registered operands/op to coprocessor1
//   cp_res              coprocessor1 result (combinational from cp_*)
//   busy, done, done_fd status; done pulses for the writeback cycle
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new op; cp_* hold the last op's operands
// DRIVE  | operands held on cp_*, counting down to the writeback edge
// DONE   | writeback completed on the previous edge; done pulse

module fpu_issue_ctrl #(
    parameter int NUM_FREGS  = 32,
    parameter int RESULT_LAT = 2,
    parameter int OP_W       = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [OP_W-1:0]              issue_op,
    input  logic [$clog2(NUM_FREGS)-1:0] issue_fs,
    input  logic [$clog2(NUM_FREGS)-1:0] issue_ft,
    input  logic [$clog2(NUM_FREGS)-1:0] issue_fd,
    input  logic                         mtc1_en,
    input  logic [$clog2(NUM_FREGS)-1:0] mtc1_addr,
    input  logic [31:0]                  mtc1_data,
    input  logic [$clog2(NUM_FREGS)-1:0] mfc1_addr,
    output logic [31:0]                  mfc1_data,
    output logic [31:0]                  cp_data1,
    output logic [31:0]                  cp_data2,
    output logic [OP_W-1:0]              cp_op,
    input  logic [31:0]                  cp_res,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_FREGS)-1:0] done_fd
);

    localparam int AW = $clog2(NUM_FREGS);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   fd_q, fd_d;
    logic [AW-1:0]   done_fd_q, done_fd_d;
    logic [31:0]     data1_q, data1_d;
    logic [31:0]     data2_q, data2_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            wb_en;

    logic [31:0]     freg_q [NUM_FREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fd_q      <= '0;
            done_fd_q <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fd_q      <= fd_d;
            done_fd_q <= done_fd_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            op_q      <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fd_d      = fd_q;
        done_fd_d = done_fd_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        op_d      = op_q;
        wb_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    // Operands are snapshots of the file before this edge.
                    data1_d = freg_q[issue_fs];
                    data2_d = freg_q[issue_ft];
                    op_d    = issue_op;
                    fd_d    = issue_fd;
                    cnt_d   = CW'(RESULT_LAT);
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    wb_en     = 1'b1;
                    done_fd_d = fd_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Writeback is assigned last so it wins over an mtc1 to the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FREGS; i++) begin
                freg_q[i] <= '0;
            end
        end else begin
            if (mtc1_en) begin
                freg_q[mtc1_addr] <= mtc1_data;
            end
            if (wb_en) begin
                freg_q[fd_q] <= cp_res;
            end
        end
    end

    assign mfc1_data   = freg_q[mfc1_addr];
    assign cp_data1    = data1_q;
    assign cp_data2    = data2_q;
    assign cp_op       = op_q;
    assign issue_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_DRIVE) || (state_q == S_DONE);
    assign done        = (state_q == S_DONE);
    assign done_fd     = done_fd_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, issue_valid, mtc1_en;
    logic [2:0]  issue_op;
    logic [4:0]  issue_fs, issue_ft, issue_fd, mtc1_addr, mfc1_addr;
    logic [31:0] mtc1_data;

    logic        issue_ready, busy, done;
    logic [31:0] mfc1_data, cp_data1, cp_data2, cp_res;
    logic [2:0]  cp_op;
    logic [4:0]  done_fd;

    logic        a1_ready, a1_busy, a1_done;
    logic [31:0] a1_mfc1, a1_d1, a1_d2, a1_res;
    logic [2:0]  a1_op;
    logic [4:0]  a1_fd;

    logic        a15_ready, a15_busy, a15_done;
    logic [31:0] a15_mfc1, a15_d1, a15_d2, a15_res;
    logic [2:0]  a15_op;
    logic [4:0]  a15_fd;

    // Coprocessor1 stand-in: known single-precision sums for add.s, simple
    // integer functions for the other codes.
    function automatic logic [31:0] cop(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: begin
                if      (a == 32'h42C80000 && b == 32'h41C80000) r = 32'h42FA0000;
                else if (a == 32'hC1B80000 && b == 32'hC5AF3800) r = 32'hC5AFF000;
                else if (a == 32'h3F800000 && b == 32'h3F800000) r = 32'h40000000;
                else                                              r = a + b;
            end
            3'd1:    r = a - b;
            3'd2:    r = a ^ b;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            default: r = {a[15:0], b[15:0]};
        endcase
        return r;
    endfunction

    assign cp_res  = cop(cp_op, cp_data1, cp_data2);
    assign a1_res  = cop(a1_op, a1_d1, a1_d2);
    assign a15_res = cop(a15_op, a15_d1, a15_d2);

    fpu_issue_ctrl #(.NUM_FREGS(32), .RESULT_LAT(LAT), .OP_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .mtc1_en(mtc1_en), .mtc1_addr(mtc1_addr), .mtc1_data(mtc1_data),
        .mfc1_addr(mfc1_addr), .mfc1_data(mfc1_data), .cp_data1(cp_data1),
        .cp_data2(cp_data2), .cp_op(cp_op), .cp_res(cp_res), .busy(busy),
        .done(done), .done_fd(done_fd));

    fpu_issue_ctrl #(.NUM_FREGS(32), .RESULT_LAT(1), .OP_W(3)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(a1_ready),
        .issue_op(issue_op), .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .mtc1_en(mtc1_en), .mtc1_addr(mtc1_addr), .mtc1_data(mtc1_data),
        .mfc1_addr(mfc1_addr), .mfc1_data(a1_mfc1), .cp_data1(a1_d1),
        .cp_data2(a1_d2), .cp_op(a1_op), .cp_res(a1_res), .busy(a1_busy),
        .done(a1_done), .done_fd(a1_fd));

    fpu_issue_ctrl #(.NUM_FREGS(32), .RESULT_LAT(15), .OP_W(3)) u_dut_lat15 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(a15_ready),
        .issue_op(issue_op), .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .mtc1_en(mtc1_en), .mtc1_addr(mtc1_addr), .mtc1_data(mtc1_data),
        .mfc1_addr(mfc1_addr), .mfc1_data(a15_mfc1), .cp_data1(a15_d1),
        .cp_data2(a15_d2), .cp_op(a15_op), .cp_res(a15_res), .busy(a15_busy),
        .done(a15_done), .done_fd(a15_fd));

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  fs, ft, fd;
        logic [31:0] vs, vt, exp;
    } vec_t;

    typedef struct {
        logic [4:0]  fd;
        logic [31:0] val;
    } sb_t;

    vec_t        vecs [6];
    sb_t         sbq [$];
    logic [31:0] model_f [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_mtc1(input logic [4:0] a, input logic [31:0] d);
        mtc1_en   = 1'b1;
        mtc1_addr = a;
        mtc1_data = d;
        @(negedge clk);
        mtc1_en    = 1'b0;
        model_f[a] = d;
    endtask

    // Drive one op for a single edge; the scoreboard entry is computed from
    // the bench's own register model at the moment of the handshake.
    task automatic issue_one(input logic [2:0] op, input logic [4:0] fs,
                             input logic [4:0] ft, input logic [4:0] fd);
        sb_t e;
        chk("ready_before_issue", issue_ready, 1'b1);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_fs    = fs;
        issue_ft    = ft;
        issue_fd    = fd;
        e.fd  = fd;
        e.val = cop(op, model_f[fs], model_f[ft]);
        sbq.push_back(e);
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic check_wb();
        sb_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: done seen with no op outstanding at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("done_fd", {27'd0, done_fd}, {27'd0, e.fd});
            mfc1_addr = e.fd;
            #1;
            chk("wb_value", mfc1_data, e.val);
            model_f[e.fd] = e.val;
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (done) check_wb();
    endtask

    initial begin
        int k, low, kd1, kd2, kd15;
        logic got_a;

        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  32'h42C80000, 32'h41C80000, 32'h42FA0000};
        vecs[1] = '{3'd0, 5'd4,  5'd5,  5'd6,  32'hC1B80000, 32'hC5AF3800, 32'hC5AFF000};
        vecs[2] = '{3'd0, 5'd7,  5'd8,  5'd9,  32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[3] = '{3'd2, 5'd10, 5'd11, 5'd0,  32'h0000FFFF, 32'h12345678, 32'h1234A987};
        vecs[4] = '{3'd0, 5'd13, 5'd13, 5'd13, 32'h11111111, 32'h11111111, 32'h22222222};
        vecs[5] = '{3'd7, 5'd14, 5'd15, 5'd31, 32'hAAAA1234, 32'hBBBB5678, 32'h12345678};
        for (int i = 0; i < 32; i++) model_f[i] = '0;

        rst_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_fs = '0; issue_ft = '0;
        issue_fd = '0; mtc1_en = 1'b0; mtc1_addr = '0; mtc1_data = '0; mfc1_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_fd", {27'd0, done_fd}, 32'd0);
        chk("rst_cp_data1", cp_data1, 32'd0);
        chk("rst_cp_data2", cp_data2, 32'd0);
        chk("rst_cp_op", {29'd0, cp_op}, 32'd0);
        mfc1_addr = 5'd17; #1;
        chk("rst_f17", mfc1_data, 32'd0);

        // Table of single ops: load sources, issue, check latency and result.
        for (int i = 0; i < 6; i++) begin
            do_mtc1(vecs[i].fs, vecs[i].vs);
            do_mtc1(vecs[i].ft, vecs[i].vt);
            issue_one(vecs[i].op, vecs[i].fs, vecs[i].ft, vecs[i].fd);
            chk("cp_data1", cp_data1, vecs[i].vs);
            chk("cp_data2", cp_data2, vecs[i].vt);
            chk("cp_op", {29'd0, cp_op}, {29'd0, vecs[i].op});
            chk("busy_drive", {31'd0, busy}, 32'd1);
            chk("ready_drive", {31'd0, issue_ready}, 32'd0);
            wait_done(k);
            chk("latency", k, LAT);
            chk("table_result", mfc1_data, vecs[i].exp);
            @(negedge clk);
            chk("done_pulse_end", {31'd0, done}, 32'd0);
            chk("done_fd_hold", {27'd0, done_fd}, {27'd0, vecs[i].fd});
            chk("ready_after", {31'd0, issue_ready}, 32'd1);
        end

        // issue_valid held high across two ops; B consumes A's result.
        do_mtc1(5'd20, 32'h0F0F0F0F);
        do_mtc1(5'd21, 32'h00FF00FF);
        begin
            sb_t e;
            issue_valid = 1'b1; issue_op = 3'd2; issue_fs = 5'd20; issue_ft = 5'd21;
            issue_fd = 5'd22;
            e.fd = 5'd22; e.val = cop(3'd2, model_f[20], model_f[21]);
            sbq.push_back(e);
            @(negedge clk);
            issue_op = 3'd1; issue_fs = 5'd22; issue_ft = 5'd21; issue_fd = 5'd23;
            low = 0; k = 0; got_a = 1'b0;
            while (!issue_ready && k < 40) begin
                low++;
                chk("held_cp_data1", cp_data1, 32'h0F0F0F0F);
                chk("held_cp_data2", cp_data2, 32'h00FF00FF);
                if (done) begin
                    check_wb();
                    got_a = 1'b1;
                end
                @(negedge clk);
                k++;
            end
            chk("ready_low_cycles", low, LAT + 1);
            chk("first_op_done", {31'd0, got_a}, 32'd1);
            e.fd = 5'd23; e.val = cop(3'd1, model_f[22], model_f[21]);
            sbq.push_back(e);
            @(negedge clk);
            issue_valid = 1'b0;
            chk("second_cp_data1", cp_data1, 32'h0FF00FF0);
            wait_done(k);
            chk("second_latency", k, LAT);
            chk("second_result", mfc1_data, 32'h0FF00FF0 - 32'h00FF00FF);
        end

        // mtc1 to fs during DRIVE is ignored; mtc1 to fd on the writeback edge is dropped.
        do_mtc1(5'd24, 32'h00000005);
        do_mtc1(5'd25, 32'h00000003);
        issue_one(3'd1, 5'd24, 5'd25, 5'd26);
        mtc1_en = 1'b1; mtc1_addr = 5'd24; mtc1_data = 32'h00000100;
        @(negedge clk);
        model_f[24] = 32'h00000100;
        mtc1_addr = 5'd26; mtc1_data = 32'hDEADBEEF;
        @(negedge clk);
        mtc1_en = 1'b0;
        chk("done_wb_clash", {31'd0, done}, 32'd1);
        if (done) check_wb();
        chk("snapshot_result", mfc1_data, 32'h00000002);
        mfc1_addr = 5'd24; #1;
        chk("mtc1_in_drive", mfc1_data, 32'h00000100);
        @(negedge clk);

        // mtc1 to a different register on the writeback edge: both land.
        issue_one(3'd1, 5'd24, 5'd25, 5'd27);
        for (int j = 0; j < LAT - 1; j++) @(negedge clk);
        mtc1_en = 1'b1; mtc1_addr = 5'd28; mtc1_data = 32'hCAFEF00D;
        @(negedge clk);
        mtc1_en = 1'b0;
        model_f[28] = 32'hCAFEF00D;
        chk("done_wb_other", {31'd0, done}, 32'd1);
        if (done) check_wb();
        chk("wb_other_result", mfc1_data, 32'h000000FD);
        mfc1_addr = 5'd28; #1;
        chk("mtc1_other", mfc1_data, 32'hCAFEF00D);
        @(negedge clk);

        // Reset in the middle of DRIVE aborts the op and clears the file.
        issue_one(3'd4, 5'd1, 5'd2, 5'd29);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        for (int i = 0; i < 32; i++) model_f[i] = '0;
        chk("abort_ready", {31'd0, issue_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cp_data1", cp_data1, 32'd0);
        for (int j = 0; j < LAT + 2; j++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        chk("abort_done_fd", {27'd0, done_fd}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            mfc1_addr = 5'(i); #1;
            chk("abort_freg_zero", mfc1_data, 32'd0);
        end

        // Latency scaling: same op on RESULT_LAT = 1, 2 and 15 builds.
        do_mtc1(5'd1, 32'h42C80000);
        do_mtc1(5'd2, 32'h41C80000);
        chk("lat1_ready", {31'd0, a1_ready}, 32'd1);
        chk("lat15_ready", {31'd0, a15_ready}, 32'd1);
        issue_one(3'd0, 5'd1, 5'd2, 5'd3);
        kd1 = -1; kd2 = -1; kd15 = -1;
        for (int j = 0; j < 20; j++) begin
            if (a1_done  && kd1  < 0) kd1  = j;
            if (done     && kd2  < 0) begin kd2 = j; check_wb(); end
            if (a15_done && kd15 < 0) kd15 = j;
            @(negedge clk);
        end
        chk("lat1_done_time", kd1, 1);
        chk("lat2_done_time", kd2, 2);
        chk("lat15_done_time", kd15, 15);
        chk("lat15_busy_after", {31'd0, a15_busy}, 32'd0);
        mfc1_addr = 5'd3; #1;
        chk("lat1_result", a1_mfc1, 32'h42FA0000);
        chk("lat2_result", mfc1_data, 32'h42FA0000);
        chk("lat15_result", a15_mfc1, 32'h42FA0000);
        chk("lat1_done_fd", {27'd0, a1_fd}, 32'd3);
        chk("lat15_done_fd", {27'd0, a15_fd}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
